mdio_responder: RTL and testbench

- PHY-side MDIO (IEEE 802.3 Clause 22) responder: the management-slave end of the MDC/MDIO link.
- Runs on one fast system clock and oversamples the external MDC and MDIO.
- Decodes read and write frames addressed to its PHY address.
- Exposes a simple register-port handshake to a local register bank, and drives read data back onto MDIO through a split tri-state interface.

---
 rtl/mdio_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_mdio_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_responder.sv
// Clause 22 MDIO PHY-side responder; oversamples MDC/MDIO on the system clock.
// Optional `MDIO_BCAST_EN: PHY address 0 is also accepted for write frames.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'b10000,
  parameter int         PREAMBLE_LEN = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        reg_wr,
  output logic [15:0] reg_wdata,
  output logic        busy,
  output logic        frame_err
);

  localparam int             PRE_W   = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PREAMBLE_LEN);

  typedef enum logic [3:0] {IDLE, ST2, OP, PHYAD, REGAD, TA, RDATA, WDATA, SKIP} state_t;

  state_t state, state_nxt;

  logic mdc_p0, mdc_p1, mdc_p2;
  logic mdio_p0, mdio_p1;
  logic tick, bit_in;

  logic [PRE_W-1:0] pre_cnt, pre_cnt_nxt;
  logic [4:0]       bit_cnt, bit_cnt_nxt;
  logic             is_read, is_read_nxt;
  logic [15:0]      shift, shift_nxt;
  logic [4:0]       addr_nxt;
  logic [15:0]      wdata_nxt;
  logic             oe_nxt, out_nxt, rd_nxt, wr_nxt, err_nxt;
  logic             rd_p1;
  logic [4:0]       phy;
  logic             read_hit, write_hit;

  // stage p0/p1: two-flop synchronisers; p2 only remembers mdc for edge detection
  always_ff @(posedge clock) begin
    mdc_p0  <= mdc;
    mdc_p1  <= mdc_p0;
    mdc_p2  <= mdc_p1;
    mdio_p0 <= mdio_in;
    mdio_p1 <= mdio_p0;
  end

  assign tick   = mdc_p1 & ~mdc_p2;
  assign bit_in = mdio_p1;

  // On the last REGAD tick the header shifter holds PHYAD in [8:4].
  assign phy      = shift[8:4];
  assign read_hit = (phy == PHY_ADDR);
`ifdef MDIO_BCAST_EN
  assign write_hit = (phy == PHY_ADDR) || (phy == 5'd0);
`else
  assign write_hit = (phy == PHY_ADDR);
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    pre_cnt_nxt = pre_cnt;
    bit_cnt_nxt = bit_cnt;
    is_read_nxt = is_read;
    shift_nxt   = shift;
    addr_nxt    = reg_addr;
    wdata_nxt   = reg_wdata;
    oe_nxt      = mdio_oe;
    out_nxt     = mdio_out;
    rd_nxt      = 1'b0;
    wr_nxt      = 1'b0;
    err_nxt     = 1'b0;

    // register bank answers two clocks after the read request
    if (rd_p1) shift_nxt = reg_rdata;

    if (tick) begin
      case (state)
        IDLE: begin
          if (bit_in) begin
            if (pre_cnt != PRE_MAX) pre_cnt_nxt = pre_cnt + PRE_W'(1);
          end else if (pre_cnt == PRE_MAX) begin
            state_nxt   = ST2;
            pre_cnt_nxt = '0;
          end else begin
            pre_cnt_nxt = '0;
          end
        end
        ST2: begin
          if (bit_in) begin
            state_nxt   = OP;
            bit_cnt_nxt = 5'd0;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
        OP: begin
          shift_nxt   = {shift[14:0], bit_in};
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd1) begin
            bit_cnt_nxt = 5'd0;
            // 10 = read, 01 = write; equal bits are malformed
            if (shift[0] != bit_in) begin
              is_read_nxt = shift[0];
              state_nxt   = PHYAD;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        PHYAD: begin
          shift_nxt   = {shift[14:0], bit_in};
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd4) begin
            bit_cnt_nxt = 5'd0;
            state_nxt   = REGAD;
          end
        end
        REGAD: begin
          shift_nxt   = {shift[14:0], bit_in};
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd4) begin
            bit_cnt_nxt = 5'd0;
            addr_nxt    = {shift[3:0], bit_in};
            if (is_read && read_hit) begin
              rd_nxt    = 1'b1;
              state_nxt = TA;
            end else if (!is_read && write_hit) begin
              state_nxt = TA;
            end else begin
              state_nxt = SKIP;
            end
          end
        end
        TA: begin
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd1) begin
            bit_cnt_nxt = 5'd0;
            if (is_read) begin
              oe_nxt    = 1'b1;
              out_nxt   = 1'b0;
              state_nxt = RDATA;
            end else begin
              state_nxt = WDATA;
            end
          end
        end
        RDATA: begin
          if (bit_cnt == 5'd16) begin
            oe_nxt      = 1'b0;
            out_nxt     = 1'b1;
            bit_cnt_nxt = 5'd0;
            state_nxt   = IDLE;
          end else begin
            out_nxt     = shift[15];
            shift_nxt   = {shift[14:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end
        WDATA: begin
          shift_nxt   = {shift[14:0], bit_in};
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd15) begin
            wdata_nxt   = {shift[14:0], bit_in};
            wr_nxt      = 1'b1;
            bit_cnt_nxt = 5'd0;
            state_nxt   = IDLE;
          end
        end
        SKIP: begin
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd17) begin
            bit_cnt_nxt = 5'd0;
            state_nxt   = IDLE;
          end
        end
        default: begin
          state_nxt   = IDLE;
          pre_cnt_nxt = '0;
          bit_cnt_nxt = 5'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    shift <= shift_nxt;
    if (!reset_n) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      bit_cnt   <= 5'd0;
      is_read   <= 1'b0;
      reg_addr  <= 5'd0;
      reg_wdata <= 16'd0;
      mdio_oe   <= 1'b0;
      mdio_out  <= 1'b1;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      frame_err <= 1'b0;
      rd_p1     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pre_cnt   <= pre_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      is_read   <= is_read_nxt;
      reg_addr  <= addr_nxt;
      reg_wdata <= wdata_nxt;
      mdio_oe   <= oe_nxt;
      mdio_out  <= out_nxt;
      reg_rd    <= rd_nxt;
      reg_wr    <= wr_nxt;
      frame_err <= err_nxt;
      rd_p1     <= reg_rd;
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Self-checking bench for mdio_responder: directed frame table, random frames, reset abort.
module tb_mdio_responder;

  localparam logic [4:0] PHY = 5'b10000;
`ifdef MDIO_BCAST_EN
  localparam logic BCAST = 1'b1;
`else
  localparam logic BCAST = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        mdc = 1'b0;
  logic        mdio_in = 1'b1;
  logic        mdio_out, mdio_oe, reg_rd, reg_wr, busy, frame_err;
  logic [4:0]  reg_addr;
  logic [15:0] reg_rdata, reg_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mdio_responder #(.PHY_ADDR(PHY), .PREAMBLE_LEN(32)) dut (
    .clock(clock), .reset_n(reset_n), .mdc(mdc), .mdio_in(mdio_in),
    .mdio_out(mdio_out), .mdio_oe(mdio_oe), .reg_addr(reg_addr),
    .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .busy(busy), .frame_err(frame_err)
  );

  // Register bank: data is valid for exactly one cycle, two clocks after reg_rd.
  logic        rd_q1 = 1'b0;
  logic [15:0] bank_val = 16'h0000;
  always @(posedge clock) rd_q1 <= reg_rd;
  assign reg_rdata = rd_q1 ? bank_val : 16'hDEAD;

  int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, busy_cnt = 0;
  logic [4:0]  wr_addr = 5'd0, rd_addr = 5'd0;
  logic [15:0] wr_data = 16'd0;
  always @(negedge clock) begin
    if (reg_wr) begin wr_cnt++; wr_addr = reg_addr; wr_data = reg_wdata; end
    if (reg_rd) begin rd_cnt++; rd_addr = reg_addr; end
    if (frame_err) err_cnt++;
    if (busy) busy_cnt++;
  end

  typedef struct {
    int          pre;
    logic        st2;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] data;
    logic        ew;
    logic        er;
    logic        ee;
  } frame_t;

  logic [4:0]  exp_addr = 5'd0;
  logic [15:0] exp_wdata = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input int pre, input logic st2, input logic [1:0] op,
                                input logic [4:0] phy, input logic [4:0] regad,
                                input logic [15:0] data, input logic ew, input logic er,
                                input logic ee);
    frame_t f;
    f.pre = pre; f.st2 = st2; f.op = op; f.phy = phy; f.regad = regad;
    f.data = data; f.ew = ew; f.er = er; f.ee = ee;
    return f;
  endfunction

  // Frame-level reference: outcome follows directly from the frame fields.
  function automatic frame_t model(input frame_t f);
    frame_t m;
    m = f;
    m.ew = 1'b0; m.er = 1'b0; m.ee = 1'b0;
    if (f.pre < 32) return m;
    if (!f.st2 || f.op == 2'b00 || f.op == 2'b11) begin
      m.ee = 1'b1;
      return m;
    end
    if (f.op == 2'b10) m.er = (f.phy == PHY);
    else m.ew = (f.phy == PHY) || (BCAST && f.phy == 5'd0);
    return m;
  endfunction

  // One MDC period of 10 clocks; returns outputs 5 clocks after the rise and
  // the number of clocks until the first output change after the rise.
  task automatic mbit(input logic b, output logic oe_s, output logic out_s, output int lat);
    logic oe0, out0;
    mdio_in = b;
    repeat (5) @(negedge clock);
    oe0 = mdio_oe;
    out0 = mdio_out;
    mdc = 1'b1;
    lat = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      if (lat == 0 && (mdio_oe !== oe0 || mdio_out !== out0)) lat = i;
    end
    oe_s = mdio_oe;
    out_s = mdio_out;
    mdc = 1'b0;
  endtask

  task automatic run_frame(input frame_t f, input string tag);
    int w0, r0, e0, b0, l, lat_ta2;
    logic o, d, tb_bit, hdr_oe, acc;
    logic [13:0] hdr;
    logic [18:0] oe_t, out_t;
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; b0 = busy_cnt;
    hdr_oe = 1'b0; lat_ta2 = 0; oe_t = '0; out_t = '0;
    bank_val = f.data;
    mbit(1'b0, o, d, l); hdr_oe |= o;
    for (int i = 0; i < f.pre; i++) begin mbit(1'b1, o, d, l); hdr_oe |= o; end
    hdr = {1'b0, f.st2, f.op, f.phy, f.regad};
    for (int i = 13; i >= 0; i--) begin mbit(hdr[i], o, d, l); hdr_oe |= o; end
    // TA, 16 data ticks, one trailing tick; station releases (ones) for reads
    for (int k = 0; k < 19; k++) begin
      if (k == 18 || f.op == 2'b10) tb_bit = 1'b1;
      else if (k < 2) tb_bit = (k == 0);
      else tb_bit = f.data[17-k];
      mbit(tb_bit, o, d, l);
      oe_t[18-k] = o;
      out_t[18-k] = d;
      if (k == 1) lat_ta2 = l;
    end
    repeat (3) @(negedge clock);

    acc = (f.pre >= 32);
    if (acc && f.st2 && (f.op == 2'b01 || f.op == 2'b10)) exp_addr = f.regad;
    if (f.ew) exp_wdata = f.data;

    chk({tag, ":wr_pulses"}, 64'(wr_cnt - w0), 64'(f.ew));
    chk({tag, ":rd_pulses"}, 64'(rd_cnt - r0), 64'(f.er));
    chk({tag, ":frame_err"}, 64'(err_cnt - e0), 64'(f.ee));
    chk({tag, ":busy_seen"}, 64'((busy_cnt - b0) > 0), 64'(acc));
    chk({tag, ":hdr_oe"}, 64'(hdr_oe), 64'(0));
    chk({tag, ":oe_tail"}, 64'(oe_t), f.er ? 64'({1'b0, 1'b1, 16'hFFFF, 1'b0}) : 64'(0));
    chk({tag, ":out_tail"}, 64'(out_t), f.er ? 64'({2'b10, f.data, 1'b1}) : 64'(19'h7FFFF));
    chk({tag, ":reg_addr"}, 64'(reg_addr), 64'(exp_addr));
    chk({tag, ":reg_wdata"}, 64'(reg_wdata), 64'(exp_wdata));
    if (f.ew) begin
      chk({tag, ":wr_addr"}, 64'(wr_addr), 64'(f.regad));
      chk({tag, ":wr_data"}, 64'(wr_data), 64'(f.data));
    end
    if (f.er) begin
      chk({tag, ":rd_addr"}, 64'(rd_addr), 64'(f.regad));
      chk({tag, ":ta2_latency"}, 64'(lat_ta2), 64'(3));
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t tbl[13];
    frame_t f;
    logic [4:0] phy_pick[4];
    logic o, d;
    logic [13:0] hdr;
    int l, r0, w0;

    tbl[0]  = mk(32, 1'b1, 2'b01, PHY,   5'd4,  16'hA5C3, 1'b1,  1'b0, 1'b0);
    tbl[1]  = mk(32, 1'b1, 2'b10, PHY,   5'd1,  16'h796D, 1'b0,  1'b1, 1'b0);
    tbl[2]  = mk(31, 1'b1, 2'b01, PHY,   5'd4,  16'h1111, 1'b0,  1'b0, 1'b0);
    tbl[3]  = mk(32, 1'b1, 2'b01, PHY,   5'd4,  16'h1111, 1'b1,  1'b0, 1'b0);
    tbl[4]  = mk(32, 1'b1, 2'b11, PHY,   5'd6,  16'hBEEF, 1'b0,  1'b0, 1'b1);
    tbl[5]  = mk(32, 1'b1, 2'b01, PHY,   5'd7,  16'h1234, 1'b1,  1'b0, 1'b0);
    tbl[6]  = mk(32, 1'b1, 2'b10, 5'd3,  5'd1,  16'h796D, 1'b0,  1'b0, 1'b0);
    tbl[7]  = mk(32, 1'b1, 2'b01, 5'd0,  5'd5,  16'h0042, BCAST, 1'b0, 1'b0);
    tbl[8]  = mk(32, 1'b0, 2'b01, PHY,   5'd5,  16'h5555, 1'b0,  1'b0, 1'b1);
    tbl[9]  = mk(32, 1'b1, 2'b00, PHY,   5'd5,  16'h5555, 1'b0,  1'b0, 1'b1);
    tbl[10] = mk(32, 1'b1, 2'b10, 5'd0,  5'd2,  16'hAAAA, 1'b0,  1'b0, 1'b0);
    tbl[11] = mk(40, 1'b1, 2'b10, PHY,   5'd31, 16'h8001, 1'b0,  1'b1, 1'b0);
    tbl[12] = mk(33, 1'b1, 2'b01, PHY,   5'd0,  16'hFFFF, 1'b1,  1'b0, 1'b0);

    repeat (4) @(negedge clock);
    chk("rst:mdio_oe", 64'(mdio_oe), 64'(0));
    chk("rst:mdio_out", 64'(mdio_out), 64'(1));
    chk("rst:strobes", 64'({reg_rd, reg_wr, frame_err}), 64'(0));
    chk("rst:busy", 64'(busy), 64'(0));
    chk("rst:reg_addr", 64'(reg_addr), 64'(0));
    chk("rst:reg_wdata", 64'(reg_wdata), 64'(0));
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 13; i++) run_frame(tbl[i], $sformatf("tbl%0d", i));

    phy_pick[0] = PHY; phy_pick[1] = 5'd0; phy_pick[2] = 5'd3; phy_pick[3] = 5'b01010;
    for (int i = 0; i < 40; i++) begin
      f = mk(int'($urandom_range(40, 28)), ($urandom_range(9, 0) != 0),
             2'($urandom_range(3, 0)), phy_pick[$urandom_range(3, 0)],
             5'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
      f = model(f);
      run_frame(f, $sformatf("rnd%0d", i));
    end

    // reset while the responder drives read data bit D7
    bank_val = 16'hC05E;
    r0 = rd_cnt; w0 = wr_cnt;
    mbit(1'b0, o, d, l);
    repeat (32) mbit(1'b1, o, d, l);
    hdr = {1'b0, 1'b1, 2'b10, PHY, 5'd2};
    for (int i = 13; i >= 0; i--) mbit(hdr[i], o, d, l);
    repeat (10) mbit(1'b1, o, d, l);
    chk("rstmid:oe_before", 64'(mdio_oe), 64'(1));
    mdio_in = 1'b1;
    repeat (5) @(negedge clock);
    mdc = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("rstmid:oe", 64'(mdio_oe), 64'(0));
    chk("rstmid:out", 64'(mdio_out), 64'(1));
    chk("rstmid:busy", 64'(busy), 64'(0));
    chk("rstmid:reg_addr", 64'(reg_addr), 64'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    mdc = 1'b0;
    repeat (3) @(negedge clock);
    chk("rstmid:rd_pulses", 64'(rd_cnt - r0), 64'(1));
    chk("rstmid:wr_pulses", 64'(wr_cnt - w0), 64'(0));
    exp_addr = 5'd0;
    exp_wdata = 16'd0;
    run_frame(mk(31, 1'b1, 2'b01, PHY, 5'd9, 16'h0F0F, 1'b0, 1'b0, 1'b0), "post_rst31");
    run_frame(mk(32, 1'b1, 2'b01, PHY, 5'd9, 16'h0F0F, 1'b1, 1'b0, 1'b0), "post_rst32");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
